// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch -- single-outstanding instruction fetch unit
//
// Issues one instruction-bus request at a time from the current pc, captures
// the returned word into a registered output for decode, and handles
// control-flow redirects at any point of a fetch. A redirect that arrives while
// a request is still in flight cannot cancel that request on the bus, so the
// response is waited for and dropped before fetching from the new target.
//
// Ports
//   clk             : clock, all state changes on the rising edge
//   reset           : synchronous active-high reset
//   ireq_valid      : instruction-bus request valid
//   ireq_addr       : instruction-bus request address (always the pc register)
//   iresp_addr_ok   : bus address acceptance, not used by this block
//   iresp_data_ok   : returned instruction data valid this cycle
//   iresp_data      : returned raw instruction
//   stall           : decode cannot accept dataF this cycle
//   redirect_valid  : control-flow change requested
//   redirect_pc     : redirect target (low two bits forced to zero)
//   dataF           : registered fetch output {valid, instr.raw_instr, instr.pc}
// -----------------------------------------------------------------------------
package fetch_pkg;
   typedef struct packed {
      logic [31:0] raw_instr;
      logic [63:0] pc;
   } instr_t;

   typedef struct packed {
      logic   valid;
      instr_t instr;
   } fetch_data_t;
endpackage

module fetch
   import fetch_pkg::*;
#(
   parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_addr_ok,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output fetch_data_t dataF
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,   // request in flight
      S_OUT     = 2'd1,   // instruction presented to decode
      S_DISCARD = 2'd2    // in-flight response belongs to an abandoned path
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] pend_pc_q, pend_pc_d;
   fetch_data_t data_q, data_d;
   logic [63:0] redirect_tgt;
   logic        unused_addr_ok;

   // Address acceptance carries no information this block needs.
   assign unused_addr_ok = iresp_addr_ok;

   // Targets are always word aligned.
   assign redirect_tgt = {redirect_pc[63:2], 2'b00};

   // The request address never differs from pc; in DISCARD pc is deliberately
   // left untouched so the outstanding request stays stable on the bus.
   assign ireq_addr = pc_q;
   assign dataF     = data_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      data_d     = data_q;
      ireq_valid = 1'b0;

      case (state_q)
         S_FETCH: begin
            ireq_valid = 1'b1;
            if (redirect_valid) begin
               if (iresp_data_ok) begin
                  // Response and redirect together: the response is stale,
                  // so start the new path straight away.
                  pc_d = redirect_tgt;
               end else begin
                  pend_pc_d = redirect_tgt;
                  state_d   = S_DISCARD;
               end
            end else if (iresp_data_ok) begin
               data_d.valid           = 1'b1;
               data_d.instr.raw_instr = iresp_data;
               data_d.instr.pc        = pc_q;
               state_d                = S_OUT;
            end
         end

         S_OUT: begin
            if (redirect_valid) begin
               data_d.valid = 1'b0;
               pc_d         = redirect_tgt;
               state_d      = S_FETCH;
            end else if (!stall) begin
               data_d.valid = 1'b0;
               pc_d         = pc_q + 64'd4;   // wraps naturally at 2^64
               state_d      = S_FETCH;
            end
         end

         S_DISCARD: begin
            ireq_valid = 1'b1;
            if (redirect_valid) begin
               pend_pc_d = redirect_tgt;     // latest redirect wins
            end
            if (iresp_data_ok) begin
               pc_d    = redirect_valid ? redirect_tgt : pend_pc_q;
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase

      // No request may be seen by the bus while the block is held in reset.
      if (reset) begin
         ireq_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= PC_RESET;
         pend_pc_q <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         data_q    <= data_d;
      end
   end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port `ireq_valid`, output, 1 bit: instruction-bus request valid.
REQ-004 SHALL have port `ireq_addr`, output, 64 bits: instruction-bus request address.
REQ-005 SHALL have port `iresp_addr_ok`, input, 1 bit: the bus accepted the address; ignored by this block.
REQ-006 SHALL have port `iresp_data_ok`, input, 1 bit: returned instruction data is valid this cycle.
REQ-007 SHALL have port `iresp_data`, input, 32 bits: returned raw instruction.
REQ-008 SHALL have port `stall`, input, 1 bit: decode cannot accept `dataF` this cycle.
REQ-009 SHALL have port `redirect_valid`, input, 1 bit: a control-flow change is requested.
REQ-010 SHALL have port `redirect_pc`, input, 64 bits: the target of the redirect.
REQ-011 SHALL have port `dataF`, output, fetch_data_t: fields `valid`, `instr.raw_instr` (32 bits) and `instr.pc` (64 bits).
REQ-012 SHALL have parameter `PC_RESET`, default 64'h8000_0000: the first fetch address.

Function
REQ-013 SHALL implement three states:
- FETCH: request in flight.
- OUT: instruction presented to decode.
- DISCARD: in-flight response is to be dropped.
REQ-014 SHALL hold register `pc` (64 bits), register `pend_pc` (64 bits) and an output register driving `dataF`; `dataF` SHALL depend only on registers.
REQ-015 In FETCH: `ireq_valid`=1 and `ireq_addr`=`pc`, held stable every cycle until `iresp_data_ok`.
REQ-016 In OUT and DISCARD: `ireq_addr`=`pc`; `ireq_valid`=1 in DISCARD and 0 in OUT.
REQ-017 In FETCH, on `iresp_data_ok` with no `redirect_valid`:
- `dataF.raw_instr` <= `iresp_data`.
- `dataF.pc` <= `pc`.
- `dataF.valid` <= 1.
- Next state OUT.
- Capture is the same edge as `data_ok`, so `dataF.valid` rises the cycle after.
REQ-018 In OUT with `stall`=0 and no `redirect_valid`:
- The instruction counts as consumed.
- `pc` <= `pc`+4.
- `dataF.valid` <= 0.
- Next state FETCH.
REQ-019 In OUT with `stall`=1 and no `redirect_valid`: all of `dataF` SHALL hold unchanged and `ireq_valid` SHALL stay 0.
REQ-020 Redirect in OUT, regardless of `stall`:
- `dataF.valid` <= 0.
- `pc` <= `redirect_pc`.
- Next state FETCH.
REQ-021 Redirect in FETCH together with `iresp_data_ok`:
- Returned data dropped.
- `pc` <= `redirect_pc`.
- Stay in FETCH.
- `dataF.valid` stays 0.
REQ-022 Redirect in FETCH without `iresp_data_ok`:
- `pend_pc` <= `redirect_pc`.
- Next state DISCARD.
- The request SHALL keep `ireq_addr` unchanged, as the bus protocol requires.
REQ-023 In DISCARD:
- A further `redirect_valid` overwrites `pend_pc` (latest wins).
- On `iresp_data_ok`: data dropped; `pc` <= (`redirect_valid` ? `redirect_pc` : `pend_pc`); next state FETCH.
REQ-024 `redirect_pc[1:0]` SHALL be forced to 0 on capture.
REQ-025 PC increment SHALL wrap modulo 2^64 without any flag.
REQ-026 At most one bus request SHALL be outstanding at any time.
REQ-027 No instruction whose fetch was overtaken by a redirect SHALL ever appear with `dataF.valid`=1.
REQ-028 `stall` SHALL have no effect in FETCH or DISCARD.

Reset
REQ-029 While `reset`=1, on each edge:
- `pc` <= PC_RESET.
- `pend_pc` <= 0.
- State <= FETCH.
- `dataF` <= all zeros, so `dataF.valid`=0.
REQ-030 `ireq_valid` SHALL be 0 in every cycle `reset` is high.
REQ-031 The first request, `ireq_addr`=PC_RESET, SHALL appear in the first cycle after `reset` falls.
REQ-032 Reset mid-operation SHALL abandon any outstanding response; a `data_ok` arriving in the reset cycle SHALL be ignored.

Verification
REQ-033 Sequential fetch:
- Stimulus: release reset; `data_ok` on the first request cycle with data 0x00000013; `stall`=0.
- Response: `dataF.valid`=1, pc=0x80000000, raw=0x00000013 for one cycle; next request addr 0x80000004.
REQ-034 Stalled hold:
- Stimulus: in OUT, hold `stall`=1 for 3 cycles.
- Response: `dataF` unchanged for 3 cycles; `ireq_valid`=0 throughout; request 0x80000004 appears the cycle after `stall` drops.
REQ-035 Redirect while waiting:
- Stimulus: `redirect_valid`=1 to 0x80000100 two cycles before `data_ok`.
- Response: `ireq_addr` stays 0x80000000 until `data_ok`; no valid output; next request addr 0x80000100.
REQ-036 Redirect with `data_ok` in the same cycle:
- Stimulus: `redirect_valid`=1 to 0x80000200 in the cycle `data_ok`=1.
- Response: data dropped; next cycle request addr 0x80000200.
REQ-037 Redirect during stall:
- Stimulus: in OUT, `stall`=1 and `redirect_valid`=1 to 0x80000300.
- Response: `dataF.valid`=0 next cycle; request addr 0x80000300.
REQ-038 Mid-flight reset:
- Stimulus: assert `reset` during FETCH with a pending response, then `data_ok` in the reset cycle.
- Response: `dataF.valid`=0; first post-reset request addr 0x80000000.
